// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache dispatch path: the FSM state
// encoding and the default widths that must agree with dcache_queue.
package dcache_pkg;

  localparam int DCACHE_DATABITS     = 32;
  localparam int DCACHE_ADDRBITS     = 32;
  localparam int DCACHE_TIMEOUT_BITS = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_WR = 2'd1,
    ISSUE_RD = 2'd2
  } disp_state_t;

endpackage

// File: rtl/dcache_dispatch_timer.sv
// Saturating per-transaction timeout counter. The count is the ordinal of
// the ISSUE cycle currently in progress: clr marks the next cycle as cycle 1,
// and tc is high on the cycle whose ordinal equals the all-ones terminal value.
module dcache_dispatch_timer #(
  parameter int TIMEOUT_BITS = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TIMEOUT_BITS-1:0] TERMINAL = '1;

  logic [TIMEOUT_BITS-1:0] count;

  // Restart on entry to an ISSUE state, otherwise count up and hold at terminal.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= TIMEOUT_BITS'(1);
    end else if (en && (count != TERMINAL)) begin
      count <= count + TIMEOUT_BITS'(1);
    end
  end

  assign tc = (count == TERMINAL);

endmodule

// File: rtl/dcache_dispatch.sv
// Drains dcache_queue one entry at a time and drives it onto the memory
// request port with a level-held req / mem_valid completion handshake.
// A write with rdreq also set is followed by a read-back of the same address.
module dcache_dispatch
  import dcache_pkg::*;
#(
  parameter int DATABITS     = DCACHE_DATABITS,
  parameter int ADDRBITS     = DCACHE_ADDRBITS,
  parameter int TIMEOUT_BITS = DCACHE_TIMEOUT_BITS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DATABITS-1:0] queue_out_data,
  input  logic [ADDRBITS-1:0] queue_out_addr,
  input  logic                queue_out_rdreq,
  input  logic                queue_out_wrreq,
  input  logic                queue_not_empty,
  output logic                queue_pop,
  output logic [ADDRBITS-1:0] mem_addr,
  output logic [DATABITS-1:0] mem_wrdata,
  output logic                mem_rdreq,
  output logic                mem_wrreq,
  input  logic                mem_valid,
  input  logic [DATABITS-1:0] mem_rddata,
  output logic [DATABITS-1:0] rsp_data,
  output logic [ADDRBITS-1:0] rsp_addr,
  output logic                rsp_valid,
  output logic                rsp_timeout,
  output logic                busy
);

  disp_state_t state;
  logic        lat_rd;
  logic        accept;
  logic        timer_clr;
  logic        timer_en;
  logic        timer_tc;

  // The head is only taken when the previous cycle did not pop, so the queue
  // has had an edge to present its new head.
  assign accept    = (state == IDLE) && queue_not_empty && !queue_pop;
  assign timer_clr = (accept && (queue_out_wrreq || queue_out_rdreq)) ||
                     ((state == ISSUE_WR) && mem_valid && lat_rd);
  assign timer_en  = (state != IDLE);

  dcache_dispatch_timer #(
    .TIMEOUT_BITS(TIMEOUT_BITS)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (timer_clr),
    .en     (timer_en),
    .tc     (timer_tc)
  );

  // Control FSM with all outputs registered; completion beats timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      lat_rd      <= 1'b0;
      queue_pop   <= 1'b0;
      mem_addr    <= '0;
      mem_wrdata  <= '0;
      mem_rdreq   <= 1'b0;
      mem_wrreq   <= 1'b0;
      rsp_data    <= '0;
      rsp_addr    <= '0;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      queue_pop   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            queue_pop  <= 1'b1;
            mem_addr   <= queue_out_addr;
            mem_wrdata <= queue_out_data;
            lat_rd     <= queue_out_rdreq;
            if (queue_out_wrreq) begin
              state     <= ISSUE_WR;
              mem_wrreq <= 1'b1;
              busy      <= 1'b1;
            end else if (queue_out_rdreq) begin
              state     <= ISSUE_RD;
              mem_rdreq <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end
        ISSUE_WR: begin
          if (mem_valid) begin
            mem_wrreq <= 1'b0;
            if (lat_rd) begin
              state     <= ISSUE_RD;
              mem_rdreq <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (timer_tc) begin
            mem_wrreq   <= 1'b0;
            rsp_timeout <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end
        end
        ISSUE_RD: begin
          if (mem_valid) begin
            rsp_data  <= mem_rddata;
            rsp_addr  <= mem_addr;
            rsp_valid <= 1'b1;
            mem_rdreq <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
          end else if (timer_tc) begin
            mem_rdreq   <= 1'b0;
            rsp_timeout <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_rdreq <= 1'b0;
          mem_wrreq <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dcache_dispatch.md
Name: dcache_dispatch

Overview:
Downstream consumer of dcache_queue. Drains queued cache requests (address, data, rdreq/wrreq) one at a time and drives them onto the memory-side request interface using a req/valid handshake. Returns read data to the cache fill path. A per-transaction timeout counter prevents a stuck memory port from hanging the cache.

Parameters:
DATABITS, 32, data word width; must match dcache_queue.
ADDRBITS, 32, address width; must match dcache_queue.
TIMEOUT_BITS, 8, width of the timeout counter; timeout fires after 2^TIMEOUT_BITS-1 cycles in ISSUE.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
queue_out_data  in  DATABITS  queue head write data
queue_out_addr  in  ADDRBITS  queue head address
queue_out_rdreq  in  1  queue head is a read
queue_out_wrreq  in  1  queue head is a write
queue_not_empty  in  1  queue head fields are valid
queue_pop  out  1  one-cycle pulse; removes the queue head at the next edge
mem_addr  out  ADDRBITS  memory request address
mem_wrdata  out  DATABITS  memory write data
mem_rdreq  out  1  read request, level-held until completion
mem_wrreq  out  1  write request, level-held until completion
mem_valid  in  1  memory completion strobe, sampled while a request is held
mem_rddata  in  DATABITS  read data; valid when mem_valid=1 and mem_rdreq=1
rsp_data  out  DATABITS  returned read data
rsp_addr  out  ADDRBITS  address of the returned read
rsp_valid  out  1  one-cycle pulse; rsp_data and rsp_addr are valid
rsp_timeout  out  1  one-cycle pulse; the current transaction was aborted
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: async on reset_n=0. State=IDLE, counter=0. All outputs 0, including the mem_* and rsp_* data buses.
- Reset mid-transaction: the request is dropped immediately. The popped entry is lost, with no rsp pulse.
- All outputs are registered.
- IDLE with queue_not_empty=1:
  - Latch the head into internal regs and pulse queue_pop for exactly one cycle.
  - rdreq=0, wrreq=0: discard; stay in IDLE.
  - wrreq=1: go to ISSUE_WR.
  - rdreq=1 only: go to ISSUE_RD.
- queue_pop never asserts outside IDLE and never on two consecutive cycles. This gives the queue a cycle to update its head.
- ISSUE_WR:
  - mem_wrreq=1, mem_addr and mem_wrdata held stable.
  - On mem_valid=1: drop mem_wrreq the next cycle. If the latched rdreq=1, go to ISSUE_RD (read-back of the same address); otherwise go to IDLE.
- ISSUE_RD:
  - mem_rdreq=1, mem_addr held stable.
  - On mem_valid=1: capture mem_rddata into rsp_data and the latched address into rsp_addr, pulse rsp_valid for one cycle, drop mem_rdreq, go to IDLE.
- mem_rdreq and mem_wrreq are never high at the same time. Each rises the cycle after entering its ISSUE state.
- Timeout counter:
  - Cleared on entry to each ISSUE state; increments every cycle spent in ISSUE_*.
  - At terminal count 2^TIMEOUT_BITS-1 with mem_valid=0: drop the request, pulse rsp_timeout, go to IDLE. A pending read-back is abandoned.
  - mem_valid=1 on the terminal-count cycle: completion wins; no timeout.
- The counter saturates and never wraps.
- mem_valid outside ISSUE is ignored.
- Throughput: the minimum is 2 cycles per single-op entry (the IDLE pop cycle plus one ISSUE cycle with an immediate mem_valid). A following entry may be popped the cycle the FSM returns to IDLE.

Decomposition:
- Package dcache_pkg holds:
  - the state encoding constants: IDLE, ISSUE_WR, ISSUE_RD;
  - the default widths shared with dcache_queue.
- Sub-module dcache_dispatch_timer: TIMEOUT_BITS saturating counter with clear/enable inputs and a terminal-count output.
- The FSM and datapath registers stay in dcache_dispatch.

Test Plan:
1. Queue holds a write: data=32'hd00faffe, addr=32'hdeadbeef, wrreq=1. Respond with mem_valid after 2 cycles. Expect: one queue_pop pulse; mem_wrreq=1 with mem_addr=deadbeef and mem_wrdata=d00faffe until mem_valid; no rsp_valid; busy returns to 0.
2. Read at addr=32'h00001000. Respond with mem_valid after 3 cycles, mem_rddata=32'h12345678. Expect: one rsp_valid pulse with rsp_data=12345678 and rsp_addr=00001000.
3. Entry with rdreq=1 and wrreq=1 at addr=32'h20. Expect: a write completes first, then mem_rdreq=1 at 32'h20, then rsp_valid with the returned data; mem_rdreq and mem_wrreq never overlap.
4. Run with TIMEOUT_BITS=4 and never assert mem_valid on a read. Expect: rsp_timeout pulses after 15 ISSUE cycles; mem_rdreq drops; FSM is back in IDLE. Repeat with mem_valid on cycle 15: expect rsp_valid and no timeout.
5. Two entries, the first with rdreq=0 and wrreq=0, then a valid write, with immediate mem_valid. Expect: the first entry is discarded, the write issues, queue_pop is never high on consecutive cycles, and the total is ≤4 cycles.
6. Pulse reset_n low while mem_rdreq=1. Expect: all outputs 0 asynchronously, no rsp pulse, and normal operation on the next entry after release.
